icache_controller: RTL and testbench
====================================

# icache_controller

Direct-mapped instruction cache that sits between the CPU fetch stage and the block-oriented instruction memory. It answers 32-bit instruction fetches from the CPU combinationally on a hit. On a miss it acts as the initiator of the memory's block-read handshake (`mem_read` / `mem_address` / `mem_busywait` / `mem_readdata`) to fetch a 128-bit line. It also keeps hit and miss counters for the context-switch performance experiments.

## Interface
Parameters:
- `NUM_LINES`, 8: cache lines. Must be a power of 2. `INDEX_W = log2(NUM_LINES)`.
- `CNT_W`, 32: width of the hit and miss counters.

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high. Clears valid bits, FSM, counters and the memory request.
- `read`  in  1  CPU fetch request.
- `address`  in  32  CPU byte address (PC). `[1:0]` ignored.
- `instruction`  out  32  fetched word. Valid when `read=1` and `busywait=0`.
- `busywait`  out  1  stall to the CPU.
- `mem_read`  out  1  block-read request to instruction memory.
- `mem_address`  out  28  block address (`PC[31:4]`).
- `mem_readdata`  in  128  line from memory. Byte 0 is in `[7:0]`.
- `mem_busywait`  in  1  memory stall. Low while `mem_read=1` means the final beat is being captured this edge.
- `hit_count`  out  CNT_W  completed hits since reset.
- `miss_count`  out  CNT_W  misses since reset.

## Operation
- Address split:
  - offset = `address[3:2]` (word within line)
  - index = `address[INDEX_W+3:4]`
  - tag = `address[31:INDEX_W+4]`
- Storage per line: `valid`, `tag`, 128-bit `data`.
- Hit = `valid[index] && tag[index]==tag`.
- FSM states: IDLE, MEM_READ, UPDATE.
  - IDLE:
    - `busywait = read && !hit`.
    - On a hit, `instruction = data[index]` word `[offset]` (word n = bits `[32n+31:32n]`).
    - On a miss at the edge: latch block address and index, increment `miss_count`, go to MEM_READ.
    - `hit_count` increments on each edge with `read && hit`.
  - MEM_READ:
    - `mem_read=1`, `mem_address` = latched block address, `busywait=1`.
    - On the edge where `mem_busywait=0`: go to UPDATE and drop `mem_read` from the next cycle.
  - UPDATE:
    - `busywait=1`, `mem_read=0`.
    - Write `mem_readdata` into the line at the latched index, set valid, write the tag; go to IDLE.
    - The request then re-evaluates as a hit.
- Outside MEM_READ, `mem_read=0` and `mem_address` holds its last value.
- `read` dropping or `address` changing during MEM_READ/UPDATE does not abort the fill. This keeps the memory beat counter aligned. The fill completes using the latched address.
- Counters wrap modulo 2^CNT_W.
- `instruction` is don't-care when `busywait=1`. It is driven as 0 when `read=0`.

## Timing
- Reset values:
  - `busywait=0` (with `read=0`), `mem_read=0`, `mem_address=0`, `instruction=0`
  - `hit_count=0`, `miss_count=0`, all valid bits 0, state IDLE.
- Hit latency: 0 cycles (combinational from `address`). No stall.
- Miss latency with the 16-beat memory:
  - 1 IDLE cycle + 16 MEM_READ cycles + 1 UPDATE cycle = 18 stall cycles.
  - The instruction is presented in the 19th cycle.
  - `mem_read` is high for exactly 16 consecutive cycles.
- `mem_readdata` is sampled only in UPDATE, one cycle after the completing beat. The memory's last byte lands on that completing edge.
- Reset during MEM_READ or UPDATE:
  - Next cycle: IDLE, `mem_read=0`, no line written.
  - The memory is reset by the same `reset`.
- Refilling a valid line with a different tag overwrites it, with no writeback. Instruction memory is read-only.

## Structure
- `icache_pkg`: FSM state enum (IDLE, MEM_READ, UPDATE), `LINE_W=128`, `MEM_ADDR_W=28`, `WORD_OFF_W=2`.
- One sub-module, `icache_line_array`: valid/tag/data storage with a combinational read port and a synchronous write port. Valid bits are cleared on reset.
- The FSM, address split and counters live in `icache_controller`.

## Test plan
- Cold miss:
  - Memory bytes 0..15 = `13 00 80 3e 93 80 20 00 13 01 21 03 b3 01 10 00`.
  - Fetch `address=0x0`.
  - Expect: `busywait` high for 18 cycles, `mem_read` high for 16 cycles, `mem_address=0`.
  - Then `instruction=0x3e800013`, `miss_count=1`.
- Same-line hits: fetch `0x4`, `0x8`, `0xC` back-to-back.
  - Expect `0x00208093`, `0x03210113`, `0x001001b3` with no stall.
  - `hit_count` advances by 3.
- Conflict (NUM_LINES=8): fetch `0x80` after `0x0`.
  - Expect a miss with `mem_address=0x8` and line 0 replaced.
  - A refetch of `0x0` misses again; `miss_count=3`.
- Abandoned request: drop `read` on cycle 5 of MEM_READ.
  - Expect `mem_read` to stay high for the full 16 cycles and the line to become valid.
  - A later fetch of the same address hits.
- Reset mid-fill: assert `reset` on cycle 8 of MEM_READ.
  - Expect `mem_read=0` next cycle, counters 0, all lines invalid.
  - The next fetch of `0x0` is a full 18-cycle miss.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  // Cache line width in bits (four 32-bit words).
  localparam int LINE_W     = 128;
  // Block address width: byte address bits [31:4].
  localparam int MEM_ADDR_W = 28;
  // Word-within-line offset width.
  localparam int WORD_OFF_W = 2;

  // Miss-handling FSM states.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

endpackage : icache_pkg

// File: rtl/icache_if.sv
// Bus bundles for the cache: CPU fetch side and instruction-memory block-read side.

// CPU fetch bus. The CPU is the master; the cache answers as slave.
interface icache_cpu_if;
  logic        read;
  logic [31:0] address;
  logic [31:0] instruction;
  logic        busywait;

  modport master (output read, output address, input instruction, input busywait);
  modport slave  (input read, input address, output instruction, output busywait);
endinterface : icache_cpu_if

// Instruction memory block-read bus. The cache is the master (initiator).
interface icache_mem_if;
  import icache_pkg::*;
  logic                  mem_read;
  logic [MEM_ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0]     mem_readdata;
  logic                  mem_busywait;

  modport master (output mem_read, output mem_address, input mem_readdata, input mem_busywait);
  modport slave  (input mem_read, input mem_address, output mem_readdata, output mem_busywait);
endinterface : icache_mem_if

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the cache lines: combinational read port,
// synchronous write port. Only the valid bits are cleared by reset; tag and
// data contents are meaningless while the matching valid bit is low.
module icache_line_array
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int INDEX_W   = 3,
  parameter int TAG_W     = 25
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data
);

  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] valid_next;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  // A line becomes valid when it is written; nothing ever invalidates except reset.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      assign valid_next[gi] = valid_reg[gi] | (wr_en && (wr_index == INDEX_W'(gi)));
    end
  endgenerate

  // Valid bits: cleared on reset, set on line fill.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  // Tag and data storage: plain write port, no reset needed.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_reg[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule : icache_line_array

// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: address split, hit detection,
// miss FSM driving the memory block-read handshake, and hit/miss counters.
module icache_controller
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  icache_cpu_if.slave      cpu,
  icache_mem_if.master     mem,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = MEM_ADDR_W - INDEX_W;

  logic [WORD_OFF_W-1:0] offset;
  logic [INDEX_W-1:0]    index;
  logic [TAG_W-1:0]      tag;
  logic                  unused_addr_bits;

  logic                  line_valid;
  logic [TAG_W-1:0]      line_tag;
  logic [LINE_W-1:0]     line_data;
  logic                  hit;
  logic                  fill_en;

  state_t                state_reg;
  logic                  mem_read_reg;
  logic [MEM_ADDR_W-1:0] mem_address_reg;
  logic [CNT_W-1:0]      hit_count_reg;
  logic [CNT_W-1:0]      miss_count_reg;

  assign offset           = cpu.address[3:2];
  assign index            = cpu.address[INDEX_W+3:4];
  assign tag              = cpu.address[31:INDEX_W+4];
  assign unused_addr_bits = &{1'b0, cpu.address[1:0]};

  // The fill uses the latched block address, never the live CPU address, so
  // a changed or dropped request cannot corrupt the line being written.
  // Gating with reset keeps a reset in UPDATE from writing the line.
  assign fill_en = (state_reg == UPDATE) && !reset;

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_lines (
    .clock    (clock),
    .reset    (reset),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_en    (fill_en),
    .wr_index (mem_address_reg[INDEX_W-1:0]),
    .wr_tag   (mem_address_reg[MEM_ADDR_W-1:INDEX_W]),
    .wr_data  (mem.mem_readdata)
  );

  assign hit = line_valid && (line_tag == tag);

  // Miss FSM with registered memory request and the two performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      mem_read_reg    <= 1'b0;
      mem_address_reg <= '0;
      hit_count_reg   <= '0;
      miss_count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cpu.read) begin
            if (hit) begin
              hit_count_reg <= hit_count_reg + CNT_W'(1);
            end else begin
              miss_count_reg  <= miss_count_reg + CNT_W'(1);
              mem_address_reg <= cpu.address[31:4];
              mem_read_reg    <= 1'b1;
              state_reg       <= MEM_READ;
            end
          end
        end
        MEM_READ: begin
          // Memory releases busywait on the edge its final beat completes.
          if (!mem.mem_busywait) begin
            mem_read_reg <= 1'b0;
            state_reg    <= UPDATE;
          end
        end
        UPDATE: begin
          state_reg <= IDLE;
        end
        default: begin
          mem_read_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      endcase
    end
  end

  // CPU stall and instruction word select.
  always_comb begin
    cpu.busywait    = 1'b1;
    cpu.instruction = '0;
    if (state_reg == IDLE) begin
      cpu.busywait = cpu.read && !hit;
    end
    if (cpu.read) begin
      cpu.instruction = line_data[{offset, 5'd0} +: 32];
    end
  end

  assign mem.mem_read    = mem_read_reg;
  assign mem.mem_address = mem_address_reg;
  assign hit_count       = hit_count_reg;
  assign miss_count      = miss_count_reg;

endmodule : icache_controller

// File: tb/tb_icache_controller.sv
// Directed testbench for icache_controller with a 16-beat block memory model.
module tb_icache_controller;
  import icache_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int total = 0;
  int bad   = 0;

  icache_cpu_if cpu ();
  icache_mem_if mem ();

  icache_controller #(
    .NUM_LINES (8),
    .CNT_W     (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cpu        (cpu.slave),
    .mem        (mem.master),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  // Memory contents: block 0 holds the program bytes from the test plan,
  // every other block holds word n = 0xA000_0000 | (block << 8) | n.
  function automatic logic [127:0] mem_line(input logic [27:0] blk);
    logic [31:0] base;
    if (blk == 28'd0) return 128'h001001b3_03210113_00208093_3e800013;
    base = 32'hA000_0000 | (32'(blk) << 8);
    return {base | 32'd3, base | 32'd2, base | 32'd1, base};
  endfunction

  // 16-beat memory: busywait drops on the 16th request cycle; the line is
  // registered on that completing edge.
  logic [3:0]   beat_cnt;
  logic [127:0] rdata_reg;
  assign mem.mem_busywait = !(mem.mem_read && beat_cnt == 4'd15);
  assign mem.mem_readdata = rdata_reg;

  always @(posedge clock) begin
    if (reset) begin
      beat_cnt  <= '0;
      rdata_reg <= '0;
    end else if (mem.mem_read) begin
      if (beat_cnt == 4'd15) begin
        beat_cnt  <= '0;
        rdata_reg <= mem_line(mem.mem_address);
      end else begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One fetch: count stall and mem_read cycles until busywait drops, then
  // check the returned instruction.
  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp_instr,
                       input int exp_stall, input int exp_mrc, input logic [27:0] exp_maddr);
    int stalls;
    int mrc;
    logic [27:0] seen_addr;
    @(posedge clock);
    #1;
    cpu.read    = 1'b1;
    cpu.address = addr;
    stalls      = 0;
    mrc         = 0;
    seen_addr   = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!cpu.busywait) break;
      stalls++;
      if (mem.mem_read) begin
        mrc++;
        seen_addr = mem.mem_address;
      end
    end
    $display("fetch %s addr=0x%08h instr=0x%08h stall=%0d mem_read_cycles=%0d",
             tag, addr, cpu.instruction, stalls, mrc);
    check({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    check({tag, "_mrc"}, 32'(mrc), 32'(exp_mrc));
    if (exp_mrc > 0) check({tag, "_maddr"}, 32'(seen_addr), 32'(exp_maddr));
    check({tag, "_instr"}, cpu.instruction, exp_instr);
  endtask

  // Drop the request for one cycle and check the counters.
  task automatic idle_check(input string tag, input logic [31:0] exp_hit, input logic [31:0] exp_miss);
    @(posedge clock);
    #1;
    cpu.read = 1'b0;
    @(negedge clock);
    $display("idle %s hit_count=%0d miss_count=%0d", tag, hit_count, miss_count);
    check({tag, "_hits"}, hit_count, exp_hit);
    check({tag, "_misses"}, miss_count, exp_miss);
    check({tag, "_instr0"}, cpu.instruction, 32'h0);
  endtask

  initial begin
    int mrc;
    cpu.read    = 1'b0;
    cpu.address = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    $display("reset state busywait=%0b mem_read=%0b", cpu.busywait, mem.mem_read);
    check("rst_busywait", 32'(cpu.busywait), 32'h0);
    check("rst_mem_read", 32'(mem.mem_read), 32'h0);
    check("rst_mem_address", 32'(mem.mem_address), 32'h0);
    check("rst_instr", cpu.instruction, 32'h0);
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);

    // Cold miss, then same-line hits back to back.
    fetch("cold0", 32'h0000_0000, 32'h3e800013, 18, 16, 28'h0);
    check("cold_misses", miss_count, 32'd1);
    check("cold_hits", hit_count, 32'd0);
    fetch("hit4", 32'h0000_0004, 32'h00208093, 0, 0, 28'h0);
    fetch("hit8", 32'h0000_0008, 32'h03210113, 0, 0, 28'h0);
    fetch("hitC", 32'h0000_000C, 32'h001001b3, 0, 0, 28'h0);
    idle_check("after_hits", 32'd4, 32'd1);

    // Conflict on line 0, then the original block misses again.
    fetch("conf80", 32'h0000_0080, 32'hA0000800, 18, 16, 28'h8);
    fetch("refetch0", 32'h0000_0000, 32'h3e800013, 18, 16, 28'h0);
    idle_check("after_conflict", 32'd6, 32'd3);

    // Abandoned request: read drops during the fill, which still completes.
    @(posedge clock);
    #1;
    cpu.read    = 1'b1;
    cpu.address = 32'h0000_0030;
    mrc = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (mem.mem_read) mrc++;
      if (mrc == 5 && cpu.read) cpu.read = 1'b0;
    end
    $display("abandon addr=0x00000030 mem_read_cycles=%0d busywait=%0b", mrc, cpu.busywait);
    check("abandon_mrc", 32'(mrc), 32'd16);
    check("abandon_busy", 32'(cpu.busywait), 32'h0);
    fetch("abandon_hit34", 32'h0000_0034, 32'hA0000301, 0, 0, 28'h0);
    idle_check("after_abandon", 32'd7, 32'd4);

    // Reset in the middle of a fill.
    @(posedge clock);
    #1;
    cpu.read    = 1'b1;
    cpu.address = 32'h0000_0040;
    mrc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mem.mem_read) mrc++;
      if (mrc == 8) break;
    end
    check("midfill_mrc", 32'(mrc), 32'd8);
    reset    = 1'b1;
    cpu.read = 1'b0;
    @(negedge clock);
    $display("midfill reset mem_read=%0b hits=%0d misses=%0d", mem.mem_read, hit_count, miss_count);
    check("midrst_mem_read", 32'(mem.mem_read), 32'h0);
    check("midrst_mem_address", 32'(mem.mem_address), 32'h0);
    check("midrst_hits", hit_count, 32'h0);
    check("midrst_misses", miss_count, 32'h0);
    check("midrst_busywait", 32'(cpu.busywait), 32'h0);
    reset = 1'b0;
    fetch("post_rst0", 32'h0000_0000, 32'h3e800013, 18, 16, 28'h0);
    fetch("post_rst34", 32'h0000_0034, 32'hA0000301, 18, 16, 28'h3);
    idle_check("after_reset", 32'd2, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_icache_controller
